// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes, bit-period helper.
// Latency: n/a (types, constants and a function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clock cycles per line bit, truncating; the RX channel uses the same rounding.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
// Latency: tick is high on the last cycle of every bit period; pre_tick one cycle earlier.
// Backpressure: none; clear restarts the period so the first bit has no phase error.
// Ports: clock, reset (sync, active high), clear, enable -> tick, pre_tick.
module uart_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick     = enable && (count == TERM);
  // Lets the caller register an output that must be high on the terminal cycle.
  assign pre_tick = enable && (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BYTESIZES data bits LSB first, optional parity, STOPBITS stop bits.
// Latency: sdata falls the cycle after the valid&&ready edge; frame lasts (1+BYTESIZES+par+STOPBITS)*CLKS_PER_BIT cycles.
// Backpressure: ready is high only while idle; valid is ignored while a frame is in flight.
// Ports: clock, reset (sync, active high), valid, datain[BYTESIZES] -> ready, sdata (idles high), done (pulse on last stop cycle).
module uart_tx #(
  parameter int BYTESIZES           = 8,
  parameter int BAUDRATE            = 115200,
  parameter int COUNTER_CLOCK_INPUT = 50_000_000,
  parameter int PARITY              = 0,
  parameter int STOPBITS            = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [BYTESIZES-1:0] datain,
  output logic                 ready,
  output logic                 sdata,
  output logic                 done
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(COUNTER_CLOCK_INPUT, BAUDRATE);
  // Mode 3 is undefined and falls back to no parity bit.
  localparam bit HAS_PARITY = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(BYTESIZES - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOPBITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: COUNTER_CLOCK_INPUT/BAUDRATE must be at least 2");
  end
  if (BYTESIZES < 5 || BYTESIZES > 9) begin : g_bad_bytesizes
    $error("uart_tx: BYTESIZES must be 5..9");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_tx: STOPBITS must be 1 or 2");
  end

  tx_state_t            state;
  logic [BYTESIZES-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_bit;
  logic                 tick;
  logic                 pre_tick;
  logic                 handshake;

  // ready is only ever high in IDLE, so this is also the IDLE->START condition.
  assign handshake = valid && ready;

  uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock   (clock),
    .reset   (reset),
    .clear   (handshake),
    .enable  (state != IDLE),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // sdata is registered and updated on the edge that ends each bit, so the
  // value for the next bit is selected one state ahead.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      sdata   <= 1'b1;
      done    <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sdata   <= 1'b1;
          ready   <= 1'b1;
          bit_idx <= '0;
          if (handshake) begin
            shreg   <= datain;
            par_bit <= (PARITY == PAR_ODD) ? ~(^datain) : (^datain);
            ready   <= 1'b0;
            sdata   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            sdata <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (HAS_PARITY) begin
                sdata <= par_bit;
                state <= uart_pkg::PARITY;
              end else begin
                sdata <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              sdata   <= shreg[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            sdata <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          sdata <= 1'b1;
          // done must be high during the terminal cycle, so it is set one cycle early.
          if (pre_tick && bit_idx == LAST_STOP) begin
            done <= 1'b1;
          end
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              ready   <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          sdata   <= 1'b1;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule
